sram_like_arbiter: RTL

//  Shares one sram-like master port (toward the AXI bridge) between the I-cache miss port (inst_*) and the D-cache miss port (data_*).

---
 rtl/sram_like_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Shares one sram-like master port (toward the sram-like-to-AXI bridge)
// between the I-cache miss port (inst_*) and the D-cache miss port (data_*).
// Only one transaction is outstanding at any time. The address phase of the
// chosen requester is forwarded combinationally, so no latency is added, and
// the data return is steered only to the side that owns the transaction.
//
// Handshake semantics (same on all three sram-like ports):
//   *_req is the valid of the address phase and *_addr_ok is its ready; the
//   address phase completes in a cycle where both are high. *_data_ok is a
//   single-cycle strobe with no back-pressure; *_rdata is meaningful only in
//   that cycle. A requester holds req and its attributes stable until addr_ok.
//
// Parameters
//   RR_MODE       0 = fixed priority (data wins ties, bounded by MAX_D_STREAK)
//                 1 = round-robin (the side that lost the last tie wins next)
//   MAX_D_STREAK  fixed mode: after this many consecutive data grants made
//                 while inst_req was pending, inst wins the next tie (1..15)
//
// Ports
//   clk, rst                         clock (posedge) / synchronous active-high reset
//   inst_req, inst_wr, inst_size,
//   inst_addr, inst_wdata            I-side request and attributes
//   inst_rdata, inst_addr_ok,
//   inst_data_ok                     I-side responses
//   data_req, data_wr, data_size,
//   data_addr, data_wdata            D-side request and attributes
//   data_rdata, data_addr_ok,
//   data_data_ok                     D-side responses
//   out_req, out_wr, out_size,
//   out_addr, out_wdata              shared-port request, muxed from the owner
//   out_rdata, out_addr_ok,
//   out_data_ok                      shared-port responses
//   busy                             high whenever the FSM is not IDLE
//   state_dbg                        current FSM state (0 IDLE, 1 ADDR, 2 WAIT)
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
   parameter int RR_MODE      = 0,
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,

   output logic        out_req,
   output logic        out_wr,
   output logic [1:0]  out_size,
   output logic [31:0] out_addr,
   output logic [31:0] out_wdata,
   input  logic [31:0] out_rdata,
   input  logic        out_addr_ok,
   input  logic        out_data_ok,

   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,   // no transaction; arbitrate every cycle
      S_ADDR = 2'd1,   // owner locked, address phase not yet accepted
      S_WAIT = 2'd2    // address accepted, waiting for the data return
   } state_t;

   typedef enum logic {
      SIDE_INST = 1'b0,
      SIDE_DATA = 1'b1
   } side_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
   localparam bit         USE_RR     = (RR_MODE != 0);

   state_t     state_q, state_d;
   side_t      owner_q, owner_d;
   side_t      last_tie_q, last_tie_d;
   logic [3:0] streak_q, streak_d;

   side_t      pick;       // arbitration winner, meaningful in IDLE only
   side_t      sel;        // side whose attributes drive the shared port
   logic       any_req;
   logic       tie;
   logic       sel_req;
   logic       addr_fire;  // address phase completes this cycle
   logic       data_fire;  // data return for the owner this cycle
   logic       grant;      // owner gets locked at the next edge

   // --------------------------------------------------------------------------
   // Arbitration. A lone request always wins. On a tie, round-robin mode
   // picks the side that did not win the previous tie; fixed mode favours
   // data until data has won MAX_D_STREAK grants in a row against a waiting
   // inst request.
   // --------------------------------------------------------------------------
   always_comb begin
      any_req = inst_req | data_req;
      tie     = inst_req & data_req;
      pick    = SIDE_INST;
      if (tie) begin
         if (USE_RR) begin
            if (last_tie_q == SIDE_INST) begin
               pick = SIDE_DATA;
            end else begin
               pick = SIDE_INST;
            end
         end else begin
            if (streak_q == STREAK_MAX) begin
               pick = SIDE_INST;
            end else begin
               pick = SIDE_DATA;
            end
         end
      end else if (data_req) begin
         pick = SIDE_DATA;
      end
   end

   // In IDLE the fresh pick drives the port so the address goes out in the
   // same cycle the request appears; afterwards the locked owner does.
   always_comb begin
      if (state_q == S_IDLE) begin
         sel = pick;
      end else begin
         sel = owner_q;
      end
   end

   // --------------------------------------------------------------------------
   // Shared-port attribute mux
   // --------------------------------------------------------------------------
   always_comb begin
      sel_req   = inst_req;
      out_wr    = inst_wr;
      out_size  = inst_size;
      out_addr  = inst_addr;
      out_wdata = inst_wdata;
      if (sel == SIDE_DATA) begin
         sel_req   = data_req;
         out_wr    = data_wr;
         out_size  = data_size;
         out_addr  = data_addr;
         out_wdata = data_wdata;
      end
   end

   // out_req is forced low in WAIT (one outstanding transaction) and while
   // reset is asserted, so nothing is accepted during the reset cycle.
   always_comb begin
      out_req = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE, S_ADDR: out_req = sel_req;
            default:        out_req = 1'b0;
         endcase
      end
   end

   // An addr_ok seen while out_req is low is not a handshake and is ignored;
   // a data_ok outside WAIT likewise belongs to no transaction.
   assign addr_fire = out_req & out_addr_ok;
   assign data_fire = !rst && (state_q == S_WAIT) && out_data_ok;

   // --------------------------------------------------------------------------
   // Response routing: only the selected / owning side sees a handshake.
   // --------------------------------------------------------------------------
   assign inst_addr_ok = addr_fire && (sel == SIDE_INST);
   assign data_addr_ok = addr_fire && (sel == SIDE_DATA);
   assign inst_data_ok = data_fire && (owner_q == SIDE_INST);
   assign data_data_ok = data_fire && (owner_q == SIDE_DATA);
   assign inst_rdata   = out_rdata;
   assign data_rdata   = out_rdata;

   assign busy      = (state_q != S_IDLE);
   assign state_dbg = state_q;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_tie_d = last_tie_q;
      streak_d   = streak_q;
      grant      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant   = 1'b1;
               owner_d = pick;
               if (addr_fire) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            // The other side may raise its request here; it is not looked at
            // until this transaction has returned to IDLE.
            if (addr_fire) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Returning to IDLE here means the next pick is offered in the
            // cycle after data_ok, never in the data_ok cycle itself.
            if (out_data_ok) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The starvation counter only advances for data grants that actually
      // made a waiting inst request wait; any inst grant clears it.
      if (grant) begin
         if (pick == SIDE_INST) begin
            streak_d = 4'd0;
         end else if (inst_req && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
         end
         if (USE_RR && tie) begin
            last_tie_d = pick;
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers. A reset in ADDR or WAIT simply abandons the transaction;
   // any data_ok for it arriving later finds the FSM in IDLE and is dropped.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         owner_q    <= SIDE_DATA;
         last_tie_q <= SIDE_INST;
         streak_q   <= 4'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_tie_q <= last_tie_d;
         streak_q   <= streak_d;
      end
   end

endmodule
